// File: rtl/seven_segment_display_ctrl.sv
// Binary temperature word -> BCD (double dabble) -> time-multiplexed common-anode 7-segment scan with PWM dimming.
// Conversion occupies VALUE_WIDTH+1 cycles with value_ready low; value_valid is ignored while busy (no queuing).
module seven_segment_display_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int SIGNED       = 0,
    parameter int REFRESH_BITS = 18
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   value_valid,
    output logic                   value_ready,
    input  logic [1:0]             unit_sel,
    input  logic                   blank_lz,
    input  logic [3:0]             brightness,
    output logic [NUM_DIGITS-1:0]  anode_select,
    output logic [6:0]             LED_out,
    output logic                   overflow
);

    localparam int BCD_DIGITS = (VALUE_WIDTH * 31 + 99) / 100;
    localparam int BCD_W      = BCD_DIGITS * 4;
    localparam int EXT_DIGITS = (NUM_DIGITS > BCD_DIGITS) ? NUM_DIGITS : BCD_DIGITS;
    localparam int EXT_W      = EXT_DIGITS * 4;
    localparam int SHIFT_W    = BCD_W + VALUE_WIDTH;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int CNT_W      = $clog2(VALUE_WIDTH + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_C     = 7'b0110001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t                         state_q, state_d;
    logic [VALUE_WIDTH-1:0]         bin_q, bin_d;
    logic [BCD_W-1:0]               bcd_q, bcd_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           neg_q, neg_d;
    logic [1:0]                     unit_q, unit_d;
    logic                           blz_q, blz_d;
    logic [NUM_DIGITS-1:0][6:0]     disp_q, disp_d;
    logic                           ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS-1:0]          anode_q, anode_d;
    logic [6:0]                     led_q, led_d;

    logic                           neg_in;
    logic [VALUE_WIDTH-1:0]         mag_in;
    logic [BCD_W-1:0]               bcd_adj;
    logic [SHIFT_W-1:0]             shift_all;
    logic [EXT_DIGITS-1:0][3:0]     bcd_ext;
    logic [NUM_DIGITS-1:0][6:0]     glyph;
    logic                           has_unit;
    logic                           ovf_calc;
    logic                           pwm_on;
    logic [3:0]                     dig;
    int                             field;
    int                             sig;
    int                             need;
    int                             pos;

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (value_valid) state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        value_ready = (state_q == ST_IDLE);
    end

    // ---------------- double-dabble datapath ----------------
    always_comb begin
        neg_in = (SIGNED != 0) && value[VALUE_WIDTH-1];
        // Negating -2^(W-1) wraps to itself, which is the correct unsigned magnitude.
        mag_in = neg_in ? (~value + 1'b1) : value;

        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        shift_all = {bcd_adj, bin_q} << 1;

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        unit_d = unit_q;
        blz_d  = blz_q;
        case (state_q)
            ST_IDLE: begin
                if (value_valid) begin
                    bin_d  = mag_in;
                    bcd_d  = '0;
                    cnt_d  = '0;
                    neg_d  = neg_in;
                    unit_d = unit_sel;
                    blz_d  = blank_lz;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = shift_all;
                cnt_d          = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            unit_q <= 2'b00;
            blz_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            unit_q <= unit_d;
            blz_q  <= blz_d;
        end
    end

    // ---------------- glyph layout of the converted value ----------------
    always_comb begin
        has_unit = (unit_q == 2'b01) || (unit_q == 2'b10);
        field    = has_unit ? NUM_DIGITS - 1 : NUM_DIGITS;
        bcd_ext  = EXT_W'(bcd_q);

        sig = 1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_ext[i] != 4'd0) sig = i + 1;
        end
        need     = sig + (neg_q ? 1 : 0);
        ovf_calc = (need > field);

        glyph = '0;
        dig   = 4'd0;
        pos   = 0;
        // r counts from the rightmost digit; pos is the digit's weight inside the numeric field.
        for (int r = 0; r < NUM_DIGITS; r++) begin
            pos = has_unit ? r - 1 : r;
            dig = has_unit ? bcd_ext[(r > 0) ? r - 1 : 0] : bcd_ext[r];
            if (has_unit && (r == 0)) begin
                glyph[NUM_DIGITS-1-r] = (unit_q == 2'b01) ? SEG_F : SEG_C;
            end else if (ovf_calc) begin
                glyph[NUM_DIGITS-1-r] = SEG_MINUS;
            end else if (blz_q) begin
                if (pos < sig)                  glyph[NUM_DIGITS-1-r] = seg_digit(dig);
                else if (neg_q && (pos == sig)) glyph[NUM_DIGITS-1-r] = SEG_MINUS;
                else                            glyph[NUM_DIGITS-1-r] = SEG_BLANK;
            end else if (neg_q && (pos == field - 1)) begin
                glyph[NUM_DIGITS-1-r] = SEG_MINUS;
            end else begin
                glyph[NUM_DIGITS-1-r] = seg_digit(dig);
            end
        end

        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (state_q == ST_COMMIT) begin
            disp_d = glyph;
            ovf_d  = ovf_calc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q <= {NUM_DIGITS{SEG_BLANK}};
            ovf_q  <= 1'b0;
        end else begin
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
        end
    end

    // ---------------- scan and PWM ----------------
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == '1) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        pwm_on  = (presc_q[REFRESH_BITS-1 -: 4] < brightness) || (brightness == 4'hf);
        anode_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (pwm_on && (k == NUM_DIGITS - 1 - int'(idx_q))) anode_d[k] = 1'b0;
        end
        led_d = disp_q[idx_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            anode_q <= '1;
            led_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            led_q   <= led_d;
        end
    end

    assign anode_select = anode_q;
    assign LED_out      = led_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_seven_segment_display_ctrl.sv
// Bench for seven_segment_display_ctrl: three configurations share clock, reset and data inputs.
module tb_seven_segment_display_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] value;
    logic [1:0] unit_sel;
    logic       blank_lz;
    logic [3:0] brightness;
    logic       valid_a, valid_b, valid_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [3:0] an_a, an_b;
    logic [2:0] an_c;
    logic [6:0] led_a, led_b, led_c;
    logic       ovf_a, ovf_b, ovf_c;

    int         sel;
    logic [7:0] obs_an;
    logic [6:0] obs_led;
    logic       obs_ovf, obs_rdy;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] exp_seg[$];
    logic       exp_ovf[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seven_segment_display_ctrl #(.NUM_DIGITS(4), .VALUE_WIDTH(8), .SIGNED(0), .REFRESH_BITS(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .value(value), .value_valid(valid_a), .value_ready(rdy_a),
        .unit_sel(unit_sel), .blank_lz(blank_lz), .brightness(brightness),
        .anode_select(an_a), .LED_out(led_a), .overflow(ovf_a));

    seven_segment_display_ctrl #(.NUM_DIGITS(4), .VALUE_WIDTH(8), .SIGNED(1), .REFRESH_BITS(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .value(value), .value_valid(valid_b), .value_ready(rdy_b),
        .unit_sel(unit_sel), .blank_lz(blank_lz), .brightness(brightness),
        .anode_select(an_b), .LED_out(led_b), .overflow(ovf_b));

    seven_segment_display_ctrl #(.NUM_DIGITS(3), .VALUE_WIDTH(8), .SIGNED(0), .REFRESH_BITS(4)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .value(value), .value_valid(valid_c), .value_ready(rdy_c),
        .unit_sel(unit_sel), .blank_lz(blank_lz), .brightness(brightness),
        .anode_select(an_c), .LED_out(led_c), .overflow(ovf_c));

    always_comb begin
        obs_an  = 8'hff;
        obs_led = 7'h7f;
        obs_ovf = 1'b0;
        obs_rdy = 1'b0;
        case (sel)
            0: begin obs_an = {4'hf, an_a};  obs_led = led_a; obs_ovf = ovf_a; obs_rdy = rdy_a; end
            1: begin obs_an = {4'hf, an_b};  obs_led = led_b; obs_ovf = ovf_b; obs_rdy = rdy_b; end
            default: begin obs_an = {5'h1f, an_c}; obs_led = led_c; obs_ovf = ovf_c; obs_rdy = rdy_c; end
        endcase
    end

    function automatic logic [6:0] seg_of_char(input byte c);
        logic [6:0] s;
        case (c)
            "0": s = 7'b0000001;
            "1": s = 7'b1001111;
            "2": s = 7'b0010010;
            "3": s = 7'b0000110;
            "4": s = 7'b1001100;
            "5": s = 7'b0100100;
            "6": s = 7'b0100000;
            "7": s = 7'b0001111;
            "8": s = 7'b0000000;
            "9": s = 7'b0000100;
            "F": s = 7'b0111000;
            "C": s = 7'b0110001;
            "-": s = 7'b1111110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Anode pattern (padded to 8 bits with ones) for digit k of an n-digit display, k=0 leftmost.
    function automatic logic [7:0] pat(input int n, input int k);
        logic [7:0] p;
        p = 8'hff;
        p[n-1-k] = 1'b0;
        return p;
    endfunction

    task automatic push_exp(input string s, input logic ovf);
        for (int i = 0; i < s.len(); i++) exp_seg.push_back(seg_of_char(s[i]));
        exp_ovf.push_back(ovf);
    endtask

    task automatic start_xfer(input int dut, input logic [7:0] v, input logic [1:0] u, input logic b);
        @(negedge clk);
        value    = v;
        unit_sel = u;
        blank_lz = b;
        valid_a  = (dut == 0);
        valid_b  = (dut == 1);
        valid_c  = (dut == 2);
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int pre);
        int cnt;
        cnt = pre;
        while (obs_rdy == 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 9) begin
            errors++;
            $display("FAIL %s ready_low: got %0d cycles, expected 9", name, cnt);
        end
    endtask

    // Finds the start of the leftmost digit's slot, then pops and compares one glyph per digit.
    task automatic check_scan(input int n, input string name);
        logic [7:0] prev;
        logic [6:0] e;
        logic       eo;
        int         t;
        int         c;
        prev = obs_an;
        t = 0;
        while (!(obs_an == pat(n, 0) && prev != pat(n, 0)) && t < 400) begin
            prev = obs_an;
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 400) begin
            errors++;
            $display("FAIL %s scan_start: no slot start within 400 cycles, anode=%b", name, obs_an);
        end
        for (int k = 0; k < n; k++) begin
            e = exp_seg.pop_front();
            checks++;
            if (obs_an !== pat(n, k)) begin
                errors++;
                $display("FAIL %s anode[%0d]: got %b, expected %b", name, k, obs_an, pat(n, k));
            end
            checks++;
            if (obs_led !== e) begin
                errors++;
                $display("FAIL %s glyph[%0d]: got %b, expected %b", name, k, obs_led, e);
            end
            c = 0;
            while (obs_an == pat(n, k) && c < 100) begin
                c++;
                @(negedge clk);
            end
            checks++;
            if (c !== 16) begin
                errors++;
                $display("FAIL %s dwell[%0d]: got %0d cycles, expected 16", name, k, c);
            end
        end
        checks++;
        if (obs_an !== pat(n, 0)) begin
            errors++;
            $display("FAIL %s index_wrap: got %b, expected %b", name, obs_an, pat(n, 0));
        end
        eo = exp_ovf.pop_front();
        checks++;
        if (obs_ovf !== eo) begin
            errors++;
            $display("FAIL %s overflow: got %b, expected %b", name, obs_ovf, eo);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_an !== 8'hff) begin errors++; $display("FAIL reset_anode: got %b, expected 11111111", obs_an); end
        checks++;
        if (obs_led !== 7'h7f) begin errors++; $display("FAIL reset_led: got %b, expected 1111111", obs_led); end
        checks++;
        if (obs_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", obs_ovf); end
        checks++;
        if (obs_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", obs_rdy); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unsigned_basic();
        sel = 0;
        start_xfer(0, 8'd72, 2'b01, 1'b1);
        push_exp(" 72F", 1'b0);
        wait_idle("u72", 0);
        check_scan(4, "u72");
    endtask

    task automatic test_signed();
        sel = 1;
        start_xfer(1, 8'hF6, 2'b10, 1'b1);
        push_exp("-10C", 1'b0);
        wait_idle("s_m10", 0);
        check_scan(4, "s_m10");

        start_xfer(1, 8'hFB, 2'b10, 1'b0);
        push_exp("-05C", 1'b0);
        wait_idle("s_m05", 0);
        check_scan(4, "s_m05");

        start_xfer(1, 8'h9C, 2'b10, 1'b1);
        push_exp("---C", 1'b1);
        wait_idle("s_m100c", 0);
        check_scan(4, "s_m100c");

        start_xfer(1, 8'h9C, 2'b00, 1'b1);
        push_exp("-100", 1'b0);
        wait_idle("s_m100", 0);
        check_scan(4, "s_m100");
    endtask

    task automatic test_three_digits();
        sel = 2;
        start_xfer(2, 8'd255, 2'b01, 1'b1);
        push_exp("--F", 1'b1);
        wait_idle("n3_255", 0);
        check_scan(3, "n3_255");

        start_xfer(2, 8'd99, 2'b01, 1'b1);
        push_exp("99F", 1'b0);
        wait_idle("n3_99", 0);
        check_scan(3, "n3_99");
    endtask

    task automatic test_back_to_back();
        sel = 0;
        start_xfer(0, 8'd12, 2'b01, 1'b1);
        push_exp(" 12F", 1'b0);
        value   = 8'd33;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        wait_idle("busy_drop", 1);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_rdy !== 1'b1) begin
            errors++;
            $display("FAIL busy_drop no_queue: ready=%b, expected 1", obs_rdy);
        end
        check_scan(4, "busy_drop");
    endtask

    task automatic test_brightness();
        logic [7:0] prev;
        int         t;
        int         c;
        sel = 0;
        brightness = 4'd4;
        repeat (2) @(negedge clk);
        prev = obs_an;
        t = 0;
        while (!(obs_an == pat(4, 0) && prev != pat(4, 0)) && t < 400) begin
            prev = obs_an;
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 400) begin errors++; $display("FAIL pwm4_start: no slot start, anode=%b", obs_an); end
        c = 0;
        while (obs_an == pat(4, 0) && c < 100) begin c++; @(negedge clk); end
        checks++;
        if (c !== 4) begin errors++; $display("FAIL pwm4_on: got %0d cycles, expected 4", c); end
        c = 0;
        while (obs_an == 8'hff && c < 100) begin c++; @(negedge clk); end
        checks++;
        if (c !== 12) begin errors++; $display("FAIL pwm4_off: got %0d cycles, expected 12", c); end
        checks++;
        if (obs_an !== pat(4, 1)) begin errors++; $display("FAIL pwm4_next: got %b, expected %b", obs_an, pat(4, 1)); end

        brightness = 4'd0;
        repeat (2) @(negedge clk);
        c = 0;
        repeat (64) begin
            if (obs_an != 8'hff) c++;
            @(negedge clk);
        end
        checks++;
        if (c !== 0) begin errors++; $display("FAIL pwm0_dark: %0d cycles with an anode on, expected 0", c); end
        brightness = 4'd15;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        sel = 0;
        start_xfer(0, 8'd12, 2'b01, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs_an !== 8'hff) begin errors++; $display("FAIL midrst_anode: got %b, expected 11111111", obs_an); end
        checks++;
        if (obs_led !== 7'h7f) begin errors++; $display("FAIL midrst_led: got %b, expected 1111111", obs_led); end
        checks++;
        if (obs_rdy !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b, expected 1", obs_rdy); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (obs_rdy !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b, expected 1", obs_rdy); end
        push_exp("    ", 1'b0);
        check_scan(4, "midrst_blank");
    endtask

    initial begin
        reset_n    = 1'b0;
        value      = 8'd0;
        unit_sel   = 2'b00;
        blank_lz   = 1'b0;
        brightness = 4'd15;
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        valid_c    = 1'b0;
        sel        = 0;

        test_reset();
        test_unsigned_basic();
        test_signed();
        test_three_digits();
        test_back_to_back();
        test_brightness();
        test_reset_mid_shift();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_display_ctrl.md
Name: seven_segment_display_ctrl

Overview:
Parametrised successor to the fixed 4-digit temperature display controller. It accepts a binary temperature word through a valid/ready handshake and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes NUM_DIGITS common-anode digits, adding:
- optional signed input with a minus sign
- selectable unit glyph (none/F/C)
- leading-zero blanking
- overflow indication
- 16-level PWM brightness
It sits between the temperature datapath and the board's anode and cathode pins.

Parameters:
- NUM_DIGITS, 4, number of physical digits; range 2..8.
- VALUE_WIDTH, 8, width of value; range 4..16.
- SIGNED, 0: 1 treats value as two's complement.
- REFRESH_BITS, 18: digit dwell time is 2^REFRESH_BITS clocks; minimum 4.

Ports:
- clk, input, 1: system clock, 100 MHz on Basys 3.
- reset_n, input, 1: asynchronous, active-low reset.
- value, input, VALUE_WIDTH: temperature word, captured on acceptance.
- value_valid, input, 1: capture request.
- value_ready, output, 1: converter idle; a transfer occurs when value_valid and value_ready are both high at a clk edge.
- unit_sel, input, 2: 00 none, 01 'F', 10 'C', 11 none.
- blank_lz, input, 1: 1 blanks leading zeros. Sampled at acceptance.
- brightness, input, 4: PWM duty; 0 off, 15 full.
- anode_select, output, NUM_DIGITS: active-low digit enables. MSB is the leftmost digit.
- LED_out, output, 7: active-low cathodes, order {a,b,c,d,e,f,g}.
- overflow, output, 1: committed value does not fit the numeric field.

Behaviour:
- Reset is asynchronous, while reset_n is low:
  - anode_select = all ones, LED_out = 7'b1111111, overflow = 0, value_ready = 1.
  - Display register cleared to all blank; prescaler and digit index cleared.
  - Any conversion in progress is aborted; no partial commit.
- BCD_DIGITS = (VALUE_WIDTH*31+99)/100 (localparam).
- Magnitude = value when SIGNED=0 or value is non-negative; otherwise the two's complement negation, held in VALUE_WIDTH bits. -2^(W-1) is legal.
- Converter FSM:
  - IDLE: value_ready=1. On transfer, capture magnitude, sign, unit_sel and blank_lz, then go to SHIFT.
  - SHIFT: exactly VALUE_WIDTH cycles of add-3-then-shift; value_ready=0.
  - COMMIT: one cycle. Writes the display register and overflow; value_ready=0. Then return to IDLE.
  - value_ready is low for exactly VALUE_WIDTH+1 cycles per transfer.
  - value_valid while busy is ignored, with no queuing.
  - New glyphs are visible on the first scan slot after COMMIT.
- Display layout:
  - Unit digit: if unit_sel is F or C, the rightmost digit shows the unit glyph and the numeric field is NUM_DIGITS-1 digits. Otherwise the field is NUM_DIGITS digits.
  - Significant digits: sig = index of the most significant nonzero BCD digit + 1 (minimum 1). need = sig + (negative ? 1 : 0).
  - need > field width: overflow=1, and every numeric-field digit shows '-'. The unit glyph is still shown.
  - blank_lz=1: digits right-aligned; '-' immediately left of the most significant digit; the remaining positions blank.
  - blank_lz=0: zero-padded; '-' replaces the leftmost field digit.
  - BCD digits beyond the field width that are zero are dropped silently.
- Glyphs (LED_out):
  - 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100
  - F: 0111000
  - C: 0110001
  - '-': 1111110
  - blank: 1111111
- Scan:
  - Prescaler counts 0..2^REFRESH_BITS-1 and wraps.
  - On wrap, the digit index increments, wrapping at NUM_DIGITS-1 to 0, which is not a power-of-two wrap.
  - Index 0 is the leftmost digit.
- PWM: the digit is enabled when prescaler[REFRESH_BITS-1 -: 4] < brightness, or when brightness == 15. When disabled, anode_select = all ones.
- anode_select and LED_out are registered: one clock after the prescaler/index state that selects them.
- Exactly one anode is low when enabled.

Test Plan:
- Defaults with REFRESH_BITS=4:
  - Stimulus: value=72, unit F, blank_lz=1.
  - Response: value_ready low for 9 cycles; scan shows blank, 7, 2, F.
  - Anodes follow 0111, 1011, 1101, 1110, with 16 cycles each.
- SIGNED=1:
  - Stimulus: value=8'hF6 (-10), unit C, blank_lz=1.
  - Response: digits '-', 1, 0, C; overflow=0.
  - Repeat with blank_lz=0 and value=8'hFB (-5): digits '-', 0, 5, C.
- SIGNED=1, value=8'h9C (-100):
  - Unit C: digits '-', '-', '-', C with overflow=1.
  - Unit none: digits '-', 1, 0, 0 with overflow=0.
- NUM_DIGITS=3, VALUE_WIDTH=8, unit F:
  - value=255 gives '-', '-', F with overflow=1.
  - value=99 gives 9, 9, F.
  - Confirms the index wraps 2→0.
- Handshake and reset:
  - Pulse value_valid with value=33 while busy converting value=12: only 12 is displayed.
  - Assert reset_n low mid-SHIFT: outputs return to reset values immediately, the display stays blank after release, and value_ready=1.
- Brightness:
  - 0: anodes stay all ones.
  - 4: each digit is on for the first 4/16 of its dwell.
  - 15: on for the full dwell.
